// File: rtl/l2cache_nway.sv
// l2cache_nway: N-way set-associative, write-back, write-allocate L2 cache with
// a CMP/WB/FILL controller, tree pseudo-LRU replacement and saturating counters.
module l2cache_nway #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int ways     = 4,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_byte_enable256,
  input  logic [255:0] mem_wdata256,
  output logic [255:0] mem_rdata256,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);
  localparam int sets    = 2 ** s_index;
  localparam int lg_ways = $clog2(ways);
  localparam int plru_w  = ways - 1;

  typedef enum logic [1:0] {ST_CMP = 2'd0, ST_WB = 2'd1, ST_FILL = 2'd2} state_t;

  state_t             state_r, state_next_s;
  logic [ways-1:0]    valid_r [sets];
  logic [ways-1:0]    dirty_r [sets];
  logic [plru_w-1:0]  plru_r  [sets];
  logic [s_tag-1:0]   tag_r   [sets][ways];
  logic [255:0]       data_r  [sets][ways];
  logic [lg_ways-1:0] victim_r;
  logic [31:0]        hit_count_r;
  logic [31:0]        miss_count_r;

  logic [s_tag-1:0]   tag_s;
  logic [s_index-1:0] index_s;
  logic               req_s;
  logic               hit_s;
  logic               hit_upd_s;
  logic               miss_go_s;
  logic               fill_done_s;
  logic [ways-1:0]    hit_vec_s;
  logic [lg_ways-1:0] hit_way_s;
  logic [lg_ways-1:0] victim_s;
  logic [plru_w-1:0]  plru_next_s;

  assign tag_s   = mem_address[31 -: s_tag];
  assign index_s = mem_address[s_offset +: s_index];
  assign req_s   = mem_read | mem_write;

  assign hit_count  = rst ? 32'd0 : hit_count_r;
  assign miss_count = rst ? 32'd0 : miss_count_r;

  // Tag compare, victim choice and PLRU path update for the addressed set
  always_comb begin
    int node;
    hit_vec_s   = '0;
    hit_way_s   = '0;
    plru_next_s = plru_r[index_s];
    node        = 0;
    for (int w = 0; w < ways; w++) begin
      if (valid_r[index_s][w] && (tag_r[index_s][w] == tag_s)) begin
        hit_vec_s[w] = 1'b1;
        hit_way_s    = lg_ways'(w);
      end else begin
        hit_vec_s[w] = 1'b0;
      end
    end
    hit_s = $onehot(hit_vec_s);
    // A 0 bit steers the walk toward the lower-numbered half of the ways.
    for (int l = 0; l < lg_ways; l++) begin
      if (plru_r[index_s][node]) begin
        node = 2 * node + 2;
      end else begin
        node = 2 * node + 1;
      end
    end
    victim_s = lg_ways'(node - plru_w);
    for (int w = ways - 1; w >= 0; w--) begin
      if (!valid_r[index_s][w]) begin
        victim_s = lg_ways'(w);
      end else begin
        victim_s = victim_s;
      end
    end
    node = 0;
    for (int l = 0; l < lg_ways; l++) begin
      if (hit_way_s[lg_ways-1-l]) begin
        plru_next_s[node] = 1'b0;
        node = 2 * node + 2;
      end else begin
        plru_next_s[node] = 1'b1;
        node = 2 * node + 1;
      end
    end
  end

  // Controller next state and all externally visible handshakes
  always_comb begin
    state_next_s = state_r;
    mem_resp     = 1'b0;
    mem_rdata256 = 256'd0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = 256'd0;
    hit_upd_s    = 1'b0;
    miss_go_s    = 1'b0;
    fill_done_s  = 1'b0;
    if (rst) begin
      state_next_s = ST_CMP;
    end else begin
      case (state_r)
        ST_CMP: begin
          if (req_s && hit_s) begin
            mem_resp     = 1'b1;
            mem_rdata256 = data_r[index_s][hit_way_s];
            hit_upd_s    = 1'b1;
          end else if (req_s) begin
            miss_go_s = 1'b1;
            if (valid_r[index_s][victim_s] && dirty_r[index_s][victim_s]) begin
              state_next_s = ST_WB;
            end else begin
              state_next_s = ST_FILL;
            end
          end else begin
            state_next_s = ST_CMP;
          end
        end
        ST_WB: begin
          pmem_write   = 1'b1;
          pmem_address = {tag_r[index_s][victim_r], index_s, {s_offset{1'b0}}};
          pmem_wdata   = data_r[index_s][victim_r];
          if (pmem_resp) begin
            state_next_s = ST_FILL;
          end else begin
            state_next_s = ST_WB;
          end
        end
        ST_FILL: begin
          pmem_read    = 1'b1;
          pmem_address = {tag_s, index_s, {s_offset{1'b0}}};
          if (pmem_resp) begin
            fill_done_s  = 1'b1;
            state_next_s = ST_CMP;
          end else begin
            state_next_s = ST_FILL;
          end
        end
        default: begin
          state_next_s = ST_CMP;
        end
      endcase
    end
  end

  // Controller state, registered victim, valid/dirty/PLRU bits and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_CMP;
      victim_r     <= '0;
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
      for (int s = 0; s < sets; s++) begin
        valid_r[s] <= '0;
        dirty_r[s] <= '0;
        plru_r[s]  <= '0;
      end
    end else begin
      state_r <= state_next_s;
      if (miss_go_s) begin
        victim_r <= victim_s;
        if (miss_count_r != 32'hFFFF_FFFF) begin
          miss_count_r <= miss_count_r + 32'd1;
        end
      end
      if (hit_upd_s) begin
        plru_r[index_s] <= plru_next_s;
        if (mem_write) begin
          dirty_r[index_s][hit_way_s] <= 1'b1;
        end
        if (hit_count_r != 32'hFFFF_FFFF) begin
          hit_count_r <= hit_count_r + 32'd1;
        end
      end
      if (fill_done_s) begin
        valid_r[index_s][victim_r] <= 1'b1;
        dirty_r[index_s][victim_r] <= 1'b0;
      end
    end
  end

  // Line data and tag storage; contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (fill_done_s) begin
      data_r[index_s][victim_r] <= pmem_rdata;
      tag_r[index_s][victim_r]  <= tag_s;
    end else if (hit_upd_s && mem_write) begin
      for (int b = 0; b < 32; b++) begin
        if (mem_byte_enable256[b]) begin
          data_r[index_s][hit_way_s][8*b +: 8] <= mem_wdata256[8*b +: 8];
        end
      end
    end
  end

endmodule
